// File: rtl/bg_pkg.sv
// Shared constants, colour type and default palette for the background pixel pipeline.
package bg_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 19;
  localparam int LATENCY  = 3;
  localparam int PAL_N    = 2 ** IDX_W;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // i*17 replicates the nibble into both halves of the byte, giving 00..FF.
  function automatic rgb_t default_pal(input logic [IDX_W-1:0] i);
    rgb_t c;
    c.r = {i, i};
    c.g = {i, i};
    c.b = {i, i};
    return c;
  endfunction

endpackage

// File: rtl/bg_palette.sv
// 16-entry RGB palette: synchronous write, registered read, resets to a grey ramp.
module bg_palette
  import bg_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  rgb_t             wdata_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] raddr_i,
  output rgb_t             rdata_o
);

  rgb_t mem_q [PAL_N];
  rgb_t rdata_q;

  // Read samples the array before this edge's write lands, so a same-edge
  // lookup of the written entry returns the old colour.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < PAL_N; i++) begin
        mem_q[i] <= default_pal(IDX_W'(i));
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= rd_en_i ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bg_pixel_pipe.sv
// Background pixel pipeline: coordinates -> scrolled frame RAM address -> palette colour,
// with sync/enable delayed to stay aligned with the colour.
module bg_pixel_pipe
  import bg_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              scroll_we,
  input  logic [8:0]        scroll_y_in,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_data,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  ram_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out
);

  localparam logic [2:0] CTL_IDLE = 3'b011;  // {valid, hs, vs}: blanked, syncs inactive

  logic              pix_ok;
  logic [9:0]        y_sum;
  logic [8:0]        y_eff;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              vs_prev_q;
  logic              vs_fall;
  logic [8:0]        scroll_pending_d, scroll_pending_q;
  logic [8:0]        scroll_active_d, scroll_active_q;
  logic [LATENCY-1:0][2:0] ctl_q;
  rgb_t              pix_rgb;

  always_comb begin
    pix_ok = pix_valid && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    y_sum  = DrawY + {1'b0, scroll_active_q};
    y_eff  = (y_sum >= 10'(V_ACTIVE)) ? 9'(y_sum - 10'(V_ACTIVE)) : y_sum[8:0];
    // y*640 as y*512 + y*128 keeps this to two adders.
    addr_d = '0;
    if (pix_ok) begin
      addr_d = (ADDR_W'(y_eff) << 9) + (ADDR_W'(y_eff) << 7) + ADDR_W'(DrawX);
    end
  end

  assign vs_fall = vs_prev_q && !vs_in;

  always_comb begin
    scroll_active_d  = vs_fall ? scroll_pending_q : scroll_active_q;
    scroll_pending_d = scroll_pending_q;
    if (scroll_we && (scroll_y_in < 9'(V_ACTIVE))) begin
      scroll_pending_d = scroll_y_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q           <= '0;
      vs_prev_q        <= 1'b1;
      scroll_pending_q <= '0;
      scroll_active_q  <= '0;
      ctl_q[0]         <= CTL_IDLE;
    end else begin
      addr_q           <= addr_d;
      vs_prev_q        <= vs_in;
      scroll_pending_q <= scroll_pending_d;
      scroll_active_q  <= scroll_active_d;
      ctl_q[0]         <= {pix_ok, hs_in, vs_in};
    end
  end

  // Control delay line; stage 1 gates the palette read, the last stage drives the DAC.
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_ctl
    always_ff @(posedge Clk) begin
      if (Reset) begin
        ctl_q[gi] <= CTL_IDLE;
      end else begin
        ctl_q[gi] <= ctl_q[gi-1];
      end
    end
  end

  bg_palette u_palette (
    .clk     (Clk),
    .srst    (Reset),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (rgb_t'(pal_data)),
    .rd_en_i (ctl_q[1][2]),
    .raddr_i (ram_data),
    .rdata_o (pix_rgb)
  );

  assign read_address = addr_q;
  assign VGA_R        = pix_rgb.r;
  assign VGA_G        = pix_rgb.g;
  assign VGA_B        = pix_rgb.b;
  assign de_out       = ctl_q[LATENCY-1][2];
  assign hs_out       = ctl_q[LATENCY-1][1];
  assign vs_out       = ctl_q[LATENCY-1][0];

endmodule

// File: tb/tb_bg_pixel_pipe.sv
// Directed + random bench for bg_pixel_pipe with a frame RAM model and an output scoreboard.
module tb_bg_pixel_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        pix_valid, hs_in, vs_in, scroll_we, pal_we;
  logic [8:0]  scroll_y_in;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic [18:0] read_address;
  logic [3:0]  ram_data = 4'h0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        hs_out, vs_out, de_out;

  always #5 Clk = ~Clk;

  bg_pixel_pipe dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .hs_in(hs_in), .vs_in(vs_in), .scroll_we(scroll_we), .scroll_y_in(scroll_y_in),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .read_address(read_address), .ram_data(ram_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
  );

  // Frame RAM content: address 0 holds index 4.
  function automatic logic [3:0] ram_fn(input logic [18:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h4;
  endfunction

  always @(posedge Clk) ram_data <= ram_fn(read_address);

  typedef struct {
    int          e;
    logic [18:0] addr;
    logic        v, hs, vs, chk_de;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0, edge_n = 0;
  logic [23:0] pal_m [16];
  int          pend_m, act_m;
  logic        vsp_m;
  logic        de_chk = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] g;
      g = 8'(i * 17);
      pal_m[i] = {g, g, g};
    end
    pend_m = 0;
    act_m  = 0;
    vsp_m  = 1'b1;
  endtask

  task automatic tick();
    exp_t x;
    int   yi;
    if (Reset) begin
      sb.delete();
      model_reset();
      @(posedge Clk);
      edge_n++;
      #1;
      chk("rst_addr", read_address, 0);
      chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
      chk("rst_hs", hs_out, 1);
      chk("rst_vs", vs_out, 1);
      chk("rst_de", de_out, 0);
      $display("reset edge=%0d rgb=%06h hs=%b vs=%b de=%b", edge_n,
               {VGA_R, VGA_G, VGA_B}, hs_out, vs_out, de_out);
      return;
    end
    x.e      = edge_n;
    x.v      = pix_valid && (DrawX < 640) && (DrawY < 480);
    yi       = int'(DrawY) + act_m;
    if (yi >= 480) yi -= 480;
    x.addr   = x.v ? 19'(yi * 640 + int'(DrawX)) : 19'd0;
    x.hs     = hs_in;
    x.vs     = vs_in;
    x.chk_de = de_chk;
    x.rgb    = '0;
    sb.push_back(x);
    // Palette lookup for the entry two edges in, before this edge's write.
    foreach (sb[i]) begin
      if (sb[i].e == edge_n - 2) sb[i].rgb = sb[i].v ? pal_m[ram_fn(sb[i].addr)] : 24'h0;
    end
    if (pal_we) pal_m[pal_addr] = pal_data;
    if (vsp_m && !vs_in) act_m = pend_m;
    if (scroll_we && scroll_y_in < 480) pend_m = int'(scroll_y_in);
    vsp_m = vs_in;
    @(posedge Clk);
    edge_n++;
    #1;
    chk("addr", read_address, sb[$].addr);
    if (sb.size() > 0 && sb[0].e == edge_n - 3) begin
      x = sb.pop_front();
      chk("rgb", {VGA_R, VGA_G, VGA_B}, x.rgb);
      chk("hs", hs_out, x.hs);
      chk("vs", vs_out, x.vs);
      if (x.chk_de) chk("de", de_out, x.v);
      $display("pix edge=%0d addr=%0d rgb=%06h hs=%b vs=%b de=%b", x.e, x.addr,
               {VGA_R, VGA_G, VGA_B}, hs_out, vs_out, de_out);
    end
  endtask

  task automatic px(input int xx, input int yy, input logic pv);
    DrawX     = 10'(xx);
    DrawY     = 10'(yy);
    pix_valid = pv;
    tick();
  endtask

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    scroll_we = 1'b0; scroll_y_in = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;

    // First pixel, then a spread of in-range coordinates.
    px(0, 0, 1);
    px(1, 0, 1);
    px(17, 3, 1);
    px(320, 240, 1);
    // Last visible pixel and first out-of-range column.
    px(639, 479, 1);
    de_chk = 1'b0;
    px(640, 0, 1);
    de_chk = 1'b1;
    px(0, 0, 0);
    px(0, 0, 0);
    px(0, 0, 0);

    // Scroll requested mid-frame only applies after the vs falling edge.
    scroll_we = 1'b1; scroll_y_in = 9'd10;
    px(0, 5, 1);
    scroll_we = 1'b0;
    px(0, 5, 1);
    vs_in = 1'b0;
    px(0, 0, 0);
    px(0, 0, 0);
    vs_in = 1'b1;
    px(0, 0, 0);
    px(3, 475, 1);
    px(639, 469, 1);
    px(639, 470, 1);

    // Out-of-range scroll is dropped; coincident write waits a further frame.
    scroll_we = 1'b1; scroll_y_in = 9'd480;
    px(0, 0, 0);
    scroll_we = 1'b0;
    vs_in = 1'b0;
    px(0, 0, 0);
    vs_in = 1'b1;
    px(0, 0, 1);
    scroll_we = 1'b1; scroll_y_in = 9'd20; vs_in = 1'b0;
    px(0, 0, 0);
    scroll_we = 1'b0; vs_in = 1'b1;
    px(0, 0, 1);
    vs_in = 1'b0;
    px(0, 0, 0);
    vs_in = 1'b1;
    px(0, 0, 1);
    px(0, 0, 0);
    px(0, 0, 0);

    // Palette write on the same edge as a lookup of that entry.
    px(0, 0, 1);
    px(0, 0, 1);
    pal_we = 1'b1; pal_addr = 4'd4; pal_data = 24'hFF0000;
    px(0, 0, 1);
    pal_we = 1'b0;
    px(0, 0, 1);
    px(0, 0, 0);
    px(0, 0, 0);

    // Random sync / enable pattern.
    for (int i = 0; i < 40; i++) begin
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
      px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
         1'($urandom_range(0, 1)));
    end

    // Reset mid-line flushes the pipe and restores the grey ramp.
    hs_in = 1'b0; vs_in = 1'b1;
    px(100, 100, 1);
    px(101, 100, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; hs_in = 1'b1;
    px(0, 0, 1);
    px(5, 0, 1);
    for (int i = 0; i < 4; i++) px(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bg_pixel_pipe.md
Name: bg_pixel_pipe

Overview:
Downstream consumer of the background frame RAM. Turns VGA controller pixel coordinates into frame RAM read addresses, applies a frame-synchronous vertical scroll with wrap, and maps each returned 4-bit palette index to 24-bit RGB through a writable 16-entry palette. Delays hs/vs/display-enable by the same number of cycles, so colour and sync reach the DAC aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
IDX_W, 4, palette index width (frame RAM word)
ADDR_W, 19, frame RAM address width

Ports:
Clk  in  1  system/pixel clock
Reset  in  1  synchronous, active-high
DrawX  in  10  current pixel column from VGA controller
DrawY  in  10  current pixel row from VGA controller
pix_valid  in  1  display-enable, active-high
hs_in  in  1  hsync, active-low
vs_in  in  1  vsync, active-low
scroll_we  in  1  write strobe for pending scroll
scroll_y_in  in  9  requested vertical scroll, 0..V_ACTIVE-1
pal_we  in  1  palette write strobe
pal_addr  in  IDX_W  palette entry to write
pal_data  in  24  {R,G,B} for the palette write
read_address  out  ADDR_W  to frame RAM read port
ram_data  in  IDX_W  registered read data from frame RAM (1-cycle latency)
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
hs_out, vs_out, de_out  out  1 each  sync/enable aligned to colour

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high. All state updates on posedge Clk.
- Reset values:
  - read_address=0; VGA_R/G/B=0; de_out=0; hs_out=vs_out=1 (inactive).
  - scroll_pending=scroll_active=0.
  - Palette entry i = {i*17, i*17, i*17}, a grey ramp from 0x000000 to 0xFFFFFF.
  - vs edge detector history=1.
- Pipeline (inputs presented in cycle c):
  - Edge ending c: S1 registers read_address, valid1, hs1, vs1.
  - Edge ending c+1: frame RAM registers ram_data; this block registers valid2, hs2, vs2.
  - Edge ending c+2: palette lookup registers VGA_R/G/B; hs_out, vs_out, de_out update.
  - Outputs valid in cycle c+3. Total latency 3 cycles for colour and sync, always constant.
- Address generation:
  - v = pix_valid && DrawX<H_ACTIVE && DrawY<V_ACTIVE.
  - y_sum = DrawY + scroll_active (10 bits). y_eff = y_sum - V_ACTIVE if y_sum >= V_ACTIVE, else y_sum.
  - read_address = (y_eff<<9) + (y_eff<<7) + DrawX, i.e. y_eff*640 + DrawX. No multiplier.
  - If !v, read_address=0 and the pixel is blanked.
  - Maximum address 307199; never exceeds it.
- Colour: if valid2 is 1, RGB = palette[ram_data]; otherwise RGB=0.
- Scroll:
  - scroll_we with scroll_y_in<V_ACTIVE loads scroll_pending. Values >=V_ACTIVE are ignored; pending is unchanged.
  - scroll_active <= scroll_pending on the cycle a vs_in falling edge is detected (previous vs=1, current vs=0). The active scroll never changes mid-frame.
  - If scroll_we and the vs falling edge occur in the same cycle, active takes the old pending value; the new value applies next frame.
- Palette:
  - pal_we writes palette[pal_addr] at the edge.
  - A lookup at that same edge returns the old entry; the new entry is visible from the next edge.
  - Writes are allowed at any time and are not frame-synchronised.
- Reset mid-frame: the pipeline flushes. Outputs hold their reset values and resume 3 cycles after Reset deasserts, with no stale pixels. The palette reverts to the grey ramp.

Decomposition:
- bg_pkg holds:
  - constants H_ACTIVE, V_ACTIVE, IDX_W, ADDR_W, LATENCY=3
  - typedef rgb_t as a packed struct {logic [7:0] r, g, b}
  - function default_pal(i) returning the grey ramp
- One sub-module, bg_palette: a 16-entry rgb_t register file with a synchronous write port and a registered read port, with reset to default_pal.
- The top level holds address generation, the scroll registers, the vs edge detector, and the sync delay lines.

Test Plan:
1. Reset, then DrawX=0, DrawY=0, pix_valid=1; model RAM returns 4 → read_address=0 one cycle later; RGB=0x444444 and de_out=1 three cycles after input.
2. DrawX=639, DrawY=479, scroll 0 → read_address=307199. DrawX=640 → read_address=0 and RGB=0 at latency 3.
3. scroll_we with 10 mid-frame; DrawY=5, X=0 → address 3200 until the vs_in falling edge. After the edge, DrawY=475, X=3 → address 3203 (wrap).
4. scroll_we with 480 → pending unchanged (stays 10); next frame still uses 10. scroll_we coincident with the vs edge → value takes effect one frame later.
5. pal_we addr=4 data=0xFF0000 in cycle k; ram_data=4 at the lookup edge k → old 0x444444; at k+1 → 0xFF0000.
6. Toggle hs_in/vs_in/pix_valid with a random pattern → hs_out/vs_out/de_out equal the inputs delayed by exactly 3 cycles. Reset asserted mid-line → next-cycle outputs RGB=0, hs/vs=1, de=0, and the palette reverts to the grey ramp.
